oen_frame_loader: RTL and testbench

- Upstream feeder for the 8-lane odd-even merge sorter in the MDSA odd-even path.
- Accepts a serial word stream with a valid/ready handshake and packs one frame into an N_INPUTS-wide vector. Short frames are padded.
- Drives the sorter's data_in, direction and en. en is pulsed only while a frame is in flight, so the sorter clock-gates the rest of the time (low-power goal).
- Tracks the sorter pipeline latency and flags the cycle the sorted vector is valid at the sorter output.

---
 rtl/oen_frame_loader_if.sv | 27 ++
 rtl/oen_frame_loader.sv | 117 +++++++++++
 tb/tb_oen_frame_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/oen_frame_loader_if.sv
// Serial key-word stream into the odd-even merge sorter frame loader.
// Valid/ready handshake with frame delimiter and per-frame sort direction.
interface oen_frame_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic                  s_dir;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output s_dir,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  s_dir,
    output s_ready
  );
endinterface

// File: rtl/oen_frame_loader.sv
// Packs a serial key stream into one padded sorter frame, pulses the sorter
// enable only while a frame is in flight and flags when the result is valid.
module oen_frame_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int LATENCY    = 6,
  parameter int CNT_W      = $clog2(N_INPUTS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  oen_frame_loader_if.slave              s,
  output logic [N_INPUTS*DATA_WIDTH-1:0] sort_data,
  output logic                           sort_dir,
  output logic                           sort_en,
  output logic                           res_valid,
  output logic [CNT_W-1:0]               res_count,
  output logic                           busy
);

  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {
    ST_FILL,
    ST_FLUSH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [LW-1:0]         r_lat;
  logic [DATA_WIDTH-1:0] r_lane [N_INPUTS];
  logic                  r_dir;
  logic                  r_res_valid;
  logic [CNT_W-1:0]      r_res_count;

  logic                  w_xfer;
  logic                  w_close;
  logic                  w_first;
  logic                  w_dir;
  logic [DATA_WIDTH-1:0] w_pad;
  logic                  w_lat_done;

  // rst gates ready so nothing is accepted while reset is held
  assign s.s_ready  = (r_state == ST_FILL) & ~rst;
  assign w_xfer     = s.s_valid & s.s_ready;
  assign w_first    = (r_cnt == '0);
  assign w_close    = w_xfer &
                      (s.s_last | (r_cnt == CNT_W'(N_INPUTS - 1)));
  // a one-word frame latches and pads with the same edge's direction
  assign w_dir      = w_first ? s.s_dir : r_dir;
  assign w_pad      = {DATA_WIDTH{w_dir}};
  assign w_lat_done = (r_state == ST_FLUSH) & (r_lat == '0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FILL:  if (w_close)    w_next = ST_FLUSH;
      ST_FLUSH: if (w_lat_done) w_next = ST_FILL;
      default:                  w_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_lat       <= '0;
      r_dir       <= 1'b0;
      r_res_count <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_lat_done;
      if (w_close) begin
        r_cnt       <= '0;
        r_lat       <= LW'(LATENCY - 1);
        r_res_count <= r_cnt + 1'b1;
      end else begin
        if (w_xfer)
          r_cnt <= r_cnt + 1'b1;
        if (r_state == ST_FLUSH && r_lat != '0)
          r_lat <= r_lat - 1'b1;
      end
      if (w_xfer && w_first)
        r_dir <= s.s_dir;
    end
  end

  // lanes past the closing word get the pad on the closing edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_INPUTS; k++)
        r_lane[k] <= '0;
    end else if (w_xfer) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        if (CNT_W'(k) == r_cnt)
          r_lane[k] <= s.s_data;
        else if (w_close && CNT_W'(k) > r_cnt)
          r_lane[k] <= w_pad;
      end
    end
  end

  for (genvar k = 0; k < N_INPUTS; k++) begin : g_pack
    assign sort_data[k*DATA_WIDTH +: DATA_WIDTH] = r_lane[k];
  end

  assign sort_dir  = r_dir;
  assign sort_en   = (r_state == ST_FLUSH);
  assign busy      = (r_state == ST_FLUSH);
  assign res_valid = r_res_valid;
  assign res_count = r_res_count;

endmodule

// File: tb/tb_oen_frame_loader.sv
// Directed and randomized frames against a frame-level reference model:
// frames are word lists, padded and checked for the whole flush window.
module tb_oen_frame_loader;
  localparam int DW  = 32;
  localparam int N   = 8;
  localparam int LAT = 6;
  localparam int CW  = $clog2(N + 1);
  localparam int VW  = N * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] sort_data;
  logic          sort_dir;
  logic          sort_en;
  logic          res_valid;
  logic [CW-1:0] res_count;
  logic          busy;

  always #5 clk = ~clk;

  oen_frame_loader_if #(.DATA_WIDTH(DW)) bus ();

  oen_frame_loader #(
    .DATA_WIDTH(DW),
    .N_INPUTS  (N),
    .LATENCY   (LAT),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (bus),
    .sort_data(sort_data),
    .sort_dir (sort_dir),
    .sort_en  (sort_en),
    .res_valid(res_valid),
    .res_count(res_count),
    .busy     (busy)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] cur[$];
  logic [DW-1:0] tx[$];
  logic          m_dir;
  int            flush_left;
  bit            m_rv;
  logic [VW-1:0] m_vec;
  logic          m_vdir;
  int            m_cnt;

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    flush_left = 0;
    m_rv       = 1'b0;
    m_vec      = '0;
    m_vdir     = 1'b0;
    m_dir      = 1'b0;
    m_cnt      = 0;
  endtask

  // one clock: check outputs of this cycle, drive inputs, advance model
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit dir,
                     input bit last, output bit acc);
    bit rdy;
    bit rv_n;
    @(negedge clk);
    rdy = (flush_left == 0);
    chk("s_ready", VW'(bus.s_ready), VW'(rdy));
    chk("sort_en", VW'(sort_en), VW'(flush_left > 0));
    chk("busy", VW'(busy), VW'(flush_left > 0));
    chk("res_valid", VW'(res_valid), VW'(m_rv));
    if (m_rv)
      chk("res_count", VW'(res_count), VW'(m_cnt));
    if (flush_left > 0 || m_rv) begin
      chk("sort_data", sort_data, m_vec);
      chk("sort_dir", VW'(sort_dir), VW'(m_vdir));
    end
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_dir   = dir;
    bus.s_last  = last;
    acc  = v && rdy;
    rv_n = (flush_left == 1);
    if (flush_left > 0) begin
      flush_left--;
    end else if (acc) begin
      if (cur.size() == 0) m_dir = dir;
      cur.push_back(d);
      if (last || cur.size() == N) begin
        for (int k = 0; k < N; k++)
          m_vec[k*DW +: DW] = (k < cur.size()) ? cur[k] : {DW{m_dir}};
        m_vdir     = m_dir;
        m_cnt      = cur.size();
        flush_left = LAT;
        cur.delete();
      end
    end
    m_rv = rv_n;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  // streams tx; valid held high until accepted, optional random gaps
  task automatic send(input bit dir, input bit use_last, input int gap_pct);
    bit acc;
    int tries;
    for (int i = 0; i < tx.size(); i++) begin
      if ($urandom_range(99) < gap_pct)
        cyc(1'b0, $urandom, bit'($urandom_range(1)),
            bit'($urandom_range(1)), acc);
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 40) begin
        cyc(1'b1, tx[i], (i == 0) ? dir : bit'($urandom_range(1)),
            use_last && (i == tx.size() - 1), acc);
        tries++;
      end
      vectors++;
      assert (acc) else begin
        miscompares++;
        $error("FAIL handshake_timeout observed=%0d expected=1", acc);
      end
    end
    tx.delete();
  endtask

  task automatic rand_tx(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back($urandom);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, VW'(bus.s_ready), '0);
    chk({tag, "_data"}, sort_data, '0);
    chk({tag, "_dir"}, VW'(sort_dir), '0);
    chk({tag, "_en"}, VW'(sort_en), '0);
    chk({tag, "_rv"}, VW'(res_valid), '0);
    chk({tag, "_cnt"}, VW'(res_count), '0);
    chk({tag, "_busy"}, VW'(busy), '0);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_dir   = 1'b0;
    bus.s_last  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_rst", VW'(bus.s_ready), VW'(1));

    tx = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
    send(1'b1, 1'b1, 0);
    idle(LAT + 2);

    tx = '{32'h10, 32'h20};
    send(1'b1, 1'b1, 0);
    idle(LAT + 2);

    tx = '{32'h5, 32'hA, 32'h3};
    send(1'b0, 1'b1, 0);
    idle(LAT + 2);

    rand_tx(5);
    send(1'b1, 1'b1, 50);
    rand_tx(8);
    send(1'b0, 1'b1, 30);
    idle(LAT + 2);

    rand_tx(10);
    send(1'b1, 1'b0, 0);
    tx = '{32'h77};
    send(1'b1, 1'b1, 0);
    idle(LAT + 2);

    rand_tx(4);
    send(1'b1, 1'b1, 0);
    idle(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outs("mid_flush_rst");
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      chk("rst_no_rv", VW'(res_valid), '0);
    end
    rst = 1'b0;
    model_reset();
    #1 chk("ready_after_abort", VW'(bus.s_ready), VW'(1));
    rand_tx(6);
    send(1'b1, 1'b1, 0);
    idle(LAT + 2);

    for (int f = 0; f < 25; f++) begin
      rand_tx($urandom_range(1, N));
      send(bit'($urandom_range(1)), $urandom_range(3) != 0, 25);
    end
    tx = '{32'h1};
    send(1'b0, 1'b1, 0);
    idle(LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
